mesi_bus_controller: RTL and testbench

- Shared-bus responder on the other end of the per-line MESI coherence block's BUS output.
- Accepts one coded bus request (6-bit BUS word) from the emitting cache.
- Broadcasts the matching snoop event to all other caches, then collects their 6-bit responses (abort/write-back).
- Sequences main-memory write-back and read, then reports completion and shared status to the requester.

---
 rtl/mesi_bus_controller.sv | 229 ++++++++++++++++++++++
 tb/tb_mesi_bus_controller.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesi_bus_controller.sv
// Shared-bus responder for per-line MESI caches: decodes one BUS request,
// broadcasts the snoop, collects listener replies and sequences memory.
module mesi_bus_controller #(
    parameter int N_CACHES   = 4,
    parameter int SNOOP_WAIT = 1,
    localparam int IDW = (N_CACHES > 1) ? $clog2(N_CACHES) : 1
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [5:0]            req_bus,
    input  logic [IDW-1:0]        req_id,
    output logic                  snoop_valid,
    output logic [4:0]            snoop_event,
    output logic [N_CACHES-1:0]   snoop_mask,
    input  logic [6*N_CACHES-1:0] snoop_resp,
    input  logic [N_CACHES-1:0]   snoop_shared,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [IDW-1:0]        mem_src_id,
    input  logic                  mem_ready,
    output logic                  done,
    output logic                  shared_out,
    output logic                  err
);

    localparam int CW = (SNOOP_WAIT > 1) ? $clog2(SNOOP_WAIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_OWNWB, S_SNOOP, S_COLLECT, S_SNPWB, S_MEMRD, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_RM, OP_WM, OP_INV, OP_WB, OP_WBRM
    } op_t;

    state_t         state_q, state_d;
    op_t            op_q, op_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] src_q, src_d;
    logic           sh_q, sh_d;
    logic           abort_q, abort_d;
    logic           rerr_q, rerr_d;
    logic           err_q, err_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    op_t            dec_op;
    logic           dec_ok;
    logic           dec_bad;
    logic [N_CACHES-1:0] mask;
    logic           sh_in;
    logic           hit_any;
    logic [IDW-1:0] hit_idx;
    logic           bad_any;

    always_comb begin
        dec_op  = OP_RM;
        dec_ok  = 1'b0;
        dec_bad = 1'b0;
        unique case (req_bus[2:0])
            3'b000: ;
            3'b001: begin
                dec_ok = 1'b1;
                dec_op = OP_RM;
            end
            3'b010: begin
                dec_ok = 1'b1;
                dec_op = OP_WM;
            end
            3'b011: begin
                dec_ok = 1'b1;
                dec_op = (req_bus[5:3] == 3'b001) ? OP_WBRM : OP_WB;
            end
            3'b100: begin
                dec_ok = 1'b1;
                dec_op = (req_bus[5:3] == 3'b010) ? OP_WM : OP_INV;
            end
            default: dec_bad = 1'b1;
        endcase
    end

    always_comb begin
        mask       = '1;
        mask[id_q] = 1'b0;
    end

    // Lowest-indexed aborting listener wins the write-back slot.
    always_comb begin
        sh_in   = |(snoop_shared & mask);
        hit_any = 1'b0;
        hit_idx = '0;
        bad_any = 1'b0;
        for (int i = 0; i < N_CACHES; i++) begin
            if (mask[i]) begin
                if (snoop_resp[6*i +: 6] == 6'b010_001) begin
                    if (!hit_any) begin
                        hit_any = 1'b1;
                        hit_idx = IDW'(i);
                    end
                end else if (snoop_resp[6*i +: 6] != 6'b000_000) begin
                    bad_any = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        id_d    = id_q;
        src_d   = src_q;
        sh_d    = sh_q;
        abort_d = abort_q;
        rerr_d  = rerr_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (dec_bad) begin
                        err_d = 1'b1;
                    end else if (dec_ok) begin
                        op_d    = dec_op;
                        id_d    = req_id;
                        src_d   = req_id;
                        sh_d    = 1'b0;
                        abort_d = 1'b0;
                        rerr_d  = 1'b0;
                        cnt_d   = '0;
                        if (dec_op == OP_WB || dec_op == OP_WBRM)
                            state_d = S_OWNWB;
                        else
                            state_d = S_SNOOP;
                    end
                end
            end
            S_OWNWB: begin
                if (mem_ready) begin
                    if (op_q == OP_WB) begin
                        state_d = S_DONE;
                    end else begin
                        op_d    = OP_RM;
                        state_d = S_SNOOP;
                    end
                end
            end
            S_SNOOP: begin
                cnt_d   = '0;
                state_d = S_COLLECT;
            end
            S_COLLECT: begin
                sh_d  = sh_q | sh_in;
                cnt_d = cnt_q + CW'(1);
                if (hit_any && !abort_q) begin
                    abort_d = 1'b1;
                    src_d   = hit_idx;
                end
                if (bad_any && !rerr_q) begin
                    rerr_d = 1'b1;
                    err_d  = 1'b1;
                end
                if (cnt_q == CW'(SNOOP_WAIT - 1)) begin
                    if (abort_q || hit_any)
                        state_d = S_SNPWB;
                    else if (op_q == OP_INV)
                        state_d = S_DONE;
                    else
                        state_d = S_MEMRD;
                end
            end
            S_SNPWB: begin
                if (mem_ready)
                    state_d = (op_q == OP_WM) ? S_MEMRD : S_DONE;
            end
            S_MEMRD: begin
                if (mem_ready)
                    state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= S_IDLE;
            op_q    <= OP_RM;
            id_q    <= '0;
            src_q   <= '0;
            sh_q    <= 1'b0;
            abort_q <= 1'b0;
            rerr_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            id_q    <= id_d;
            src_q   <= src_d;
            sh_q    <= sh_d;
            abort_q <= abort_d;
            rerr_q  <= rerr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        req_ready   = (state_q == S_IDLE) && !CLR;
        snoop_valid = (state_q == S_SNOOP);
        snoop_mask  = snoop_valid ? mask : '0;
        snoop_event = 5'b00000;
        if (snoop_valid) begin
            unique case (op_q)
                OP_WM:   snoop_event = 5'b00100;
                OP_INV:  snoop_event = 5'b10000;
                default: snoop_event = 5'b00001;
            endcase
        end
        mem_wr     = (state_q == S_OWNWB) || (state_q == S_SNPWB);
        mem_rd     = (state_q == S_MEMRD);
        mem_src_id = mem_wr ? src_q : '0;
        done       = (state_q == S_DONE);
        shared_out = done && (op_q == OP_RM) && (sh_q || abort_q);
        err        = err_q;
    end

endmodule

// File: tb/tb_mesi_bus_controller.sv
// Directed bench for mesi_bus_controller: each task drives one scenario
// at the falling edge and checks cycle-exact outputs.
module tb_mesi_bus_controller;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_bus = '0;
    logic [1:0]  req_id = '0;
    logic        snoop_valid;
    logic [4:0]  snoop_event;
    logic [3:0]  snoop_mask;
    logic [23:0] snoop_resp = '0;
    logic [3:0]  snoop_shared = '0;
    logic        mem_rd;
    logic        mem_wr;
    logic [1:0]  mem_src_id;
    logic        mem_ready = 1'b1;
    logic        done;
    logic        shared_out;
    logic        err;

    int tests = 0;
    int fails = 0;

    mesi_bus_controller #(.N_CACHES(4), .SNOOP_WAIT(1)) dut (
        .CLK(CLK), .CLR(CLR),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_bus(req_bus), .req_id(req_id),
        .snoop_valid(snoop_valid), .snoop_event(snoop_event),
        .snoop_mask(snoop_mask), .snoop_resp(snoop_resp),
        .snoop_shared(snoop_shared),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_src_id(mem_src_id),
        .mem_ready(mem_ready), .done(done),
        .shared_out(shared_out), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic issue(input logic [5:0] bus, input logic [1:0] id);
        req_valid = 1'b1;
        req_bus   = bus;
        req_id    = id;
        tick();
        req_valid = 1'b0;
        req_bus   = '0;
    endtask

    task automatic test_reset();
        CLR = 1'b1;
        tick();
        tick();
        tests++;
        if ({req_ready, snoop_valid, snoop_event, snoop_mask, mem_rd, mem_wr,
             mem_src_id, done, shared_out, err} !== 17'b0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b sv=%b ev=%b m=%b rd=%b wr=%b src=%0d d=%b sh=%b e=%b, want all 0",
                     req_ready, snoop_valid, snoop_event, snoop_mask, mem_rd,
                     mem_wr, mem_src_id, done, shared_out, err);
        end
        CLR = 1'b0;
        #1;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
        tick();
    endtask

    task automatic test_rm_basic();
        mem_ready = 1'b1;
        issue(6'b000_001, 2'd0);
        tests++;
        if ({snoop_valid, snoop_event, snoop_mask, req_ready} !== {1'b1, 5'b00001, 4'b1110, 1'b0}) begin
            fails++;
            $display("FAIL rm_snoop: got v=%b ev=%b m=%b rdy=%b want 1 00001 1110 0",
                     snoop_valid, snoop_event, snoop_mask, req_ready);
        end
        tick();
        tests++;
        if ({snoop_valid, mem_rd, mem_wr, done} !== 4'b0000) begin
            fails++;
            $display("FAIL rm_collect: got v=%b rd=%b wr=%b d=%b want 0000",
                     snoop_valid, mem_rd, mem_wr, done);
        end
        tick();
        tests++;
        if ({mem_rd, mem_wr, done} !== 3'b100) begin
            fails++;
            $display("FAIL rm_memrd: got rd=%b wr=%b d=%b want 100", mem_rd, mem_wr, done);
        end
        tick();
        tests++;
        if ({done, shared_out, mem_rd} !== 3'b100) begin
            fails++;
            $display("FAIL rm_done: got d=%b sh=%b rd=%b want 100", done, shared_out, mem_rd);
        end
        tick();
        tests++;
        if ({done, req_ready} !== 2'b01) begin
            fails++;
            $display("FAIL rm_idle: got d=%b rdy=%b want 01", done, req_ready);
        end
    endtask

    task automatic test_rm_abort();
        mem_ready = 1'b0;
        issue(6'b000_001, 2'd2);
        tests++;
        if ({snoop_valid, snoop_event, snoop_mask} !== {1'b1, 5'b00001, 4'b1011}) begin
            fails++;
            $display("FAIL rma_snoop: got v=%b ev=%b m=%b want 1 00001 1011",
                     snoop_valid, snoop_event, snoop_mask);
        end
        snoop_resp[11:6] = 6'b010_001;
        tick();
        tick();
        snoop_resp = '0;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if ({mem_wr, mem_rd, mem_src_id} !== {1'b1, 1'b0, 2'd1}) begin
                fails++;
                $display("FAIL rma_snpwb%0d: got wr=%b rd=%b src=%0d want wr=1 rd=0 src=1",
                         k, mem_wr, mem_rd, mem_src_id);
            end
            if (k == 2) mem_ready = 1'b1;
            tick();
        end
        tests++;
        if ({done, shared_out, mem_rd, mem_wr} !== 4'b1100) begin
            fails++;
            $display("FAIL rma_done: got d=%b sh=%b rd=%b wr=%b want 1100",
                     done, shared_out, mem_rd, mem_wr);
        end
        tick();
    endtask

    task automatic test_wm_abort();
        mem_ready = 1'b1;
        issue(6'b010_100, 2'd3);
        tests++;
        if ({snoop_valid, snoop_event, snoop_mask} !== {1'b1, 5'b00100, 4'b0111}) begin
            fails++;
            $display("FAIL wm_snoop: got v=%b ev=%b m=%b want 1 00100 0111",
                     snoop_valid, snoop_event, snoop_mask);
        end
        snoop_resp[5:0] = 6'b010_001;
        tick();
        tick();
        snoop_resp = '0;
        tests++;
        if ({mem_wr, mem_rd, mem_src_id} !== {1'b1, 1'b0, 2'd0}) begin
            fails++;
            $display("FAIL wm_snpwb: got wr=%b rd=%b src=%0d want 1 0 0", mem_wr, mem_rd, mem_src_id);
        end
        tick();
        tests++;
        if ({mem_rd, mem_wr} !== 2'b10) begin
            fails++;
            $display("FAIL wm_memrd: got rd=%b wr=%b want 10", mem_rd, mem_wr);
        end
        tick();
        tests++;
        if ({done, shared_out} !== 2'b10) begin
            fails++;
            $display("FAIL wm_done: got d=%b sh=%b want 10", done, shared_out);
        end
        tick();
    endtask

    task automatic test_wbrm();
        mem_ready    = 1'b1;
        snoop_shared = 4'b0100;
        issue(6'b001_011, 2'd1);
        tests++;
        if ({mem_wr, mem_src_id, snoop_valid} !== {1'b1, 2'd1, 1'b0}) begin
            fails++;
            $display("FAIL wbrm_ownwb: got wr=%b src=%0d sv=%b want 1 1 0", mem_wr, mem_src_id, snoop_valid);
        end
        tick();
        tests++;
        if ({snoop_valid, snoop_event, snoop_mask, mem_wr} !== {1'b1, 5'b00001, 4'b1101, 1'b0}) begin
            fails++;
            $display("FAIL wbrm_snoop: got v=%b ev=%b m=%b wr=%b want 1 00001 1101 0",
                     snoop_valid, snoop_event, snoop_mask, mem_wr);
        end
        tick();
        tick();
        tests++;
        if ({mem_rd, mem_wr} !== 2'b10) begin
            fails++;
            $display("FAIL wbrm_memrd: got rd=%b wr=%b want 10", mem_rd, mem_wr);
        end
        tick();
        tests++;
        if ({done, shared_out} !== 2'b11) begin
            fails++;
            $display("FAIL wbrm_done: got d=%b sh=%b want 11", done, shared_out);
        end
        snoop_shared = '0;
        tick();
    endtask

    task automatic test_bad_req();
        issue(6'b000_110, 2'd0);
        tests++;
        if ({err, snoop_valid, req_ready} !== 3'b101) begin
            fails++;
            $display("FAIL badreq_err: got e=%b sv=%b rdy=%b want 101", err, snoop_valid, req_ready);
        end
        tick();
        tests++;
        if ({err, snoop_valid, done} !== 3'b000) begin
            fails++;
            $display("FAIL badreq_after: got e=%b sv=%b d=%b want 000", err, snoop_valid, done);
        end
        issue(6'b000_000, 2'd1);
        tests++;
        if ({err, snoop_valid, mem_wr, req_ready} !== 4'b0001) begin
            fails++;
            $display("FAIL nullreq: got e=%b sv=%b wr=%b rdy=%b want 0001",
                     err, snoop_valid, mem_wr, req_ready);
        end
    endtask

    task automatic test_bad_resp();
        mem_ready = 1'b1;
        issue(6'b000_001, 2'd0);
        snoop_resp[11:6] = 6'b000_011;
        tick();
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL badresp_early: got e=%b want 0", err);
        end
        tick();
        snoop_resp = '0;
        tests++;
        if ({err, mem_rd, mem_wr} !== 3'b110) begin
            fails++;
            $display("FAIL badresp_err: got e=%b rd=%b wr=%b want 110", err, mem_rd, mem_wr);
        end
        tick();
        tests++;
        if ({done, shared_out, err} !== 3'b100) begin
            fails++;
            $display("FAIL badresp_done: got d=%b sh=%b e=%b want 100", done, shared_out, err);
        end
        tick();
    endtask

    task automatic test_clr_snpwb();
        mem_ready = 1'b0;
        issue(6'b000_001, 2'd0);
        snoop_resp[17:12] = 6'b010_001;
        tick();
        tick();
        snoop_resp = '0;
        tests++;
        if ({mem_wr, mem_src_id} !== {1'b1, 2'd2}) begin
            fails++;
            $display("FAIL clr_pre: got wr=%b src=%0d want 1 2", mem_wr, mem_src_id);
        end
        CLR = 1'b1;
        tick();
        tests++;
        if ({mem_wr, mem_rd, done, req_ready, mem_src_id} !== 6'b0) begin
            fails++;
            $display("FAIL clr_abort: got wr=%b rd=%b d=%b rdy=%b src=%0d want all 0",
                     mem_wr, mem_rd, done, req_ready, mem_src_id);
        end
        CLR       = 1'b0;
        mem_ready = 1'b1;
        tick();
        tests++;
        if ({done, mem_wr, req_ready} !== 3'b001) begin
            fails++;
            $display("FAIL clr_after: got d=%b wr=%b rdy=%b want 001", done, mem_wr, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        mem_ready = 1'b1;
        issue(6'b000_100, 2'd1);
        tests++;
        if ({snoop_valid, snoop_event, snoop_mask} !== {1'b1, 5'b10000, 4'b1101}) begin
            fails++;
            $display("FAIL inv_snoop: got v=%b ev=%b m=%b want 1 10000 1101",
                     snoop_valid, snoop_event, snoop_mask);
        end
        tick();
        tick();
        tests++;
        if ({done, shared_out, mem_rd} !== 3'b100) begin
            fails++;
            $display("FAIL inv_done: got d=%b sh=%b rd=%b want 100", done, shared_out, mem_rd);
        end
        issue(6'b000_011, 2'd3);
        tests++;
        if ({mem_wr, req_ready} !== 2'b01) begin
            fails++;
            $display("FAIL ignored_req: got wr=%b rdy=%b want 01", mem_wr, req_ready);
        end
        issue(6'b000_011, 2'd3);
        tests++;
        if ({mem_wr, mem_src_id, snoop_valid} !== {1'b1, 2'd3, 1'b0}) begin
            fails++;
            $display("FAIL wb_ownwb: got wr=%b src=%0d sv=%b want 1 3 0", mem_wr, mem_src_id, snoop_valid);
        end
        tick();
        tests++;
        if ({done, shared_out, mem_wr} !== 3'b100) begin
            fails++;
            $display("FAIL wb_done: got d=%b sh=%b wr=%b want 100", done, shared_out, mem_wr);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rm_basic();
        test_rm_abort();
        test_wm_abort();
        test_wbrm();
        test_bad_req();
        test_bad_resp();
        test_clr_snpwb();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
